// File: rtl/cache_line_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side signals of the line arbiter.
// The master modport drives requests and memory responses; slave is the arbiter.
interface cache_line_arbiter_if #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_address;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  mem_resp;

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
   );

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
   );
endinterface

// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter of I-cache and D-cache line transactions onto one memory port; mem op from the cycle after the request.
// Requests are held until their resp; the loser waits in place, and memory may stall indefinitely via mem_resp.
module cache_line_arbiter #(
   parameter int LINE_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 5
) (
   input logic                clk,
   input logic                reset,
   cache_line_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_last_d;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic                  r_op_write;

   logic                  w_d_req;
   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  w_done;
   logic                  w_busy;

   assign w_d_req = bus.d_read | bus.d_write;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      w_next_state = r_state;
      w_grant_i    = 1'b0;
      w_grant_d    = 1'b0;
      w_done       = 1'b0;
      bus.i_resp   = 1'b0;
      bus.d_resp   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_read && (!w_d_req || r_last_d)) begin
               w_grant_i    = 1'b1;
               w_next_state = SERVE_I;
            end else if (w_d_req) begin
               w_grant_d    = 1'b1;
               w_next_state = SERVE_D;
            end
         end
         SERVE_I: begin
            if (bus.mem_resp) begin
               bus.i_resp   = 1'b1;
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         SERVE_D: begin
            if (bus.mem_resp) begin
               bus.d_resp   = 1'b1;
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last_d   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_op_write <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_done) begin
            r_last_d <= (r_state == SERVE_D);
         end
         if (w_grant_i) begin
            r_addr     <= bus.i_address & LINE_MASK;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
         end else if (w_grant_d) begin
            // Write wins if both d_read and d_write are raised together.
            r_addr     <= bus.d_address & LINE_MASK;
            r_wdata    <= bus.d_wdata;
            r_op_write <= bus.d_write;
         end
      end
   end

   assign w_busy          = (r_state != IDLE);
   assign bus.mem_read    = w_busy & ~r_op_write;
   assign bus.mem_write   = w_busy & r_op_write;
   assign bus.mem_address = r_addr;
   assign bus.mem_wdata   = r_op_write ? r_wdata : '0;
   assign bus.i_rdata     = bus.mem_rdata;
   assign bus.d_rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed and random stimulus for cache_line_arbiter, checked each cycle against a
// transaction-level model of who owns the memory port and what it must see.
module tb_cache_line_arbiter;
   logic clk;
   logic rst;

   cache_line_arbiter_if ifc ();

   cache_line_arbiter dut (
      .clk   (clk),
      .reset (rst),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: 0 = memory port free, 1 = I-cache owns it, 2 = D-cache owns it.
   int          m_owner = 0;
   bit          m_last_d = 1'b0;
   logic [31:0] m_addr = '0;
   bit          m_wr = 1'b0;
   logic [255:0] m_wdata = '0;

   logic        obs_mem_read, obs_mem_write, obs_iresp, obs_dresp;
   logic [31:0] obs_addr;
   logic [255:0] obs_wdata, obs_irdata;
   int          d_while_i = 0;
   int          i_while_d = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return a & ~32'h1F;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner = 0; m_last_d = 1'b0; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
      end else if (m_owner == 0) begin
         bit want_i, want_d;
         want_i = ifc.i_read;
         want_d = ifc.d_read | ifc.d_write;
         if (want_i && want_d) begin
            if (m_last_d) m_owner = 1; else m_owner = 2;
         end else if (want_i) m_owner = 1;
         else if (want_d) m_owner = 2;
         if (m_owner == 1) begin
            m_addr = line_of(ifc.i_address); m_wr = 1'b0; m_wdata = '0;
         end else if (m_owner == 2) begin
            m_addr = line_of(ifc.d_address); m_wr = ifc.d_write; m_wdata = ifc.d_wdata;
         end
      end else if (ifc.mem_resp) begin
         m_last_d = (m_owner == 2);
         m_owner  = 0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      obs_mem_read  = ifc.mem_read;
      obs_mem_write = ifc.mem_write;
      obs_addr      = ifc.mem_address;
      obs_wdata     = ifc.mem_wdata;
      obs_iresp     = ifc.i_resp;
      obs_dresp     = ifc.d_resp;
      obs_irdata    = ifc.i_rdata;
      if (chk_en) begin
         chk("mem_read",    256'(obs_mem_read),  256'(m_owner != 0 && !m_wr));
         chk("mem_write",   256'(obs_mem_write), 256'(m_owner != 0 && m_wr));
         chk("mem_address", 256'(obs_addr),      256'(m_addr));
         chk("mem_wdata",   obs_wdata,           m_wr ? m_wdata : 256'(0));
         chk("i_resp",      256'(obs_iresp),     256'(m_owner == 1 && ifc.mem_resp));
         chk("d_resp",      256'(obs_dresp),     256'(m_owner == 2 && ifc.mem_resp));
         chk("i_rdata",     obs_irdata,          ifc.mem_rdata);
         chk("d_rdata",     ifc.d_rdata,         ifc.mem_rdata);
         if (obs_dresp && ifc.i_read) d_while_i++;
         if (obs_iresp && (ifc.d_read || ifc.d_write)) i_while_d++;
         if (obs_iresp) begin
            chk("starve_i", 256'(d_while_i <= 1), 256'(1));
            d_while_i = 0;
         end
         if (obs_dresp) begin
            chk("starve_d", 256'(i_while_d <= 1), 256'(1));
            i_while_d = 0;
         end
      end
      model_step();
      if (rst) begin
         d_while_i = 0; i_while_d = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int wait_n, input logic [255:0] rd);
      repeat (wait_n) cycle();
      ifc.mem_rdata = rd;
      ifc.mem_resp  = 1'b1;
      cycle();
      ifc.mem_resp  = 1'b0;
   endtask

   initial begin
      logic [255:0] pat;
      logic [255:0] a5;
      a5  = {32{8'hA5}};
      pat = {8{32'h1234_5678}} ^ {4{64'h0F0F_00FF_3C3C_A55A}};
      rst = 1'b1;
      ifc.i_read = 0; ifc.i_address = '0;
      ifc.d_read = 0; ifc.d_write = 0; ifc.d_address = '0; ifc.d_wdata = '0;
      ifc.mem_rdata = '0; ifc.mem_resp = 0;
      cycle();
      chk_en = 1'b1;
      rst = 1'b0;
      cycle();
      chk("rst_mem_read", 256'(obs_mem_read), 256'(0));
      chk("rst_mem_addr", 256'(obs_addr), 256'(0));

      // Single I read
      ifc.i_read = 1; ifc.i_address = 32'h0000_0064;
      cycle();
      cycle();
      chk("i_single_read", 256'(obs_mem_read), 256'(1));
      chk("i_single_addr", 256'(obs_addr), 256'(32'h60));
      chk("i_single_nowr", 256'(obs_mem_write), 256'(0));
      serve(4, a5);
      chk("i_single_resp", 256'(obs_iresp), 256'(1));
      chk("i_single_rdata", obs_irdata, a5);
      chk("i_single_dresp", 256'(obs_dresp), 256'(0));
      ifc.i_read = 0;
      cycle();
      chk("i_single_done", 256'(obs_mem_read), 256'(0));

      // D write-back with wdata changing mid-transaction
      ifc.d_write = 1; ifc.d_address = 32'h0000_1F3C; ifc.d_wdata = pat;
      cycle();
      cycle();
      chk("d_wb_write", 256'(obs_mem_write), 256'(1));
      chk("d_wb_addr", 256'(obs_addr), 256'(32'h1F20));
      chk("d_wb_wdata", obs_wdata, pat);
      ifc.d_wdata = ~pat;
      cycle();
      chk("d_wb_hold", obs_wdata, pat);
      serve(2, '0);
      chk("d_wb_resp", 256'(obs_dresp), 256'(1));
      ifc.d_write = 0;
      cycle();
      chk("d_wb_pulse", 256'(obs_dresp), 256'(0));

      // Tie straight after reset goes to D
      rst = 1;
      cycle();
      rst = 0;
      ifc.i_read = 1; ifc.i_address = 32'h340;
      ifc.d_read = 1; ifc.d_address = 32'h7C4;
      cycle();
      cycle();
      chk("tie_d_first", 256'(obs_addr), 256'(32'h7C0));
      serve(1, a5);
      chk("tie_d_resp", 256'(obs_dresp), 256'(1));
      chk("tie_no_iresp", 256'(obs_iresp), 256'(0));
      ifc.d_read = 0;
      cycle();
      chk("tie_gap", 256'(obs_mem_read), 256'(0));
      cycle();
      chk("tie_i_next", 256'(obs_addr), 256'(32'h340));
      serve(0, ~a5);
      chk("tie_i_resp", 256'(obs_iresp), 256'(1));
      ifc.i_read = 0;

      // Round robin: D keeps re-requesting while I is pending
      ifc.i_address = 32'h4000; ifc.d_address = 32'h8000;
      ifc.i_read = 1; ifc.d_read = 1;
      cycle();
      cycle();
      chk("rr_d1", 256'(obs_addr), 256'(32'h8000));
      serve(1, a5);
      ifc.d_read = 0;
      cycle();
      ifc.d_read = 1;
      cycle();
      chk("rr_i1", 256'(obs_addr), 256'(32'h4000));
      serve(1, a5);
      ifc.i_read = 0;
      cycle();
      ifc.i_read = 1;
      cycle();
      chk("rr_d2", 256'(obs_addr), 256'(32'h8000));
      serve(0, a5);
      ifc.d_read = 0;
      cycle();
      cycle();
      chk("rr_i2", 256'(obs_addr), 256'(32'h4000));
      serve(0, a5);
      ifc.i_read = 0;
      cycle();

      // Spurious memory response while idle
      ifc.mem_resp = 1;
      cycle();
      chk("spur_iresp", 256'(obs_iresp), 256'(0));
      chk("spur_dresp", 256'(obs_dresp), 256'(0));
      ifc.mem_resp = 0;
      cycle();
      chk("spur_idle", 256'(obs_mem_read | obs_mem_write), 256'(0));

      // Reset in the middle of an I read
      ifc.i_read = 1; ifc.i_address = 32'h900;
      cycle();
      cycle();
      chk("mid_busy", 256'(obs_mem_read), 256'(1));
      rst = 1; ifc.i_read = 0; ifc.d_read = 1; ifc.d_address = 32'hABC;
      cycle();
      rst = 0; ifc.mem_resp = 1;
      cycle();
      chk("mid_abort", 256'(obs_mem_read), 256'(0));
      chk("mid_no_iresp", 256'(obs_iresp), 256'(0));
      ifc.mem_resp = 0;
      cycle();
      chk("mid_d_grant", 256'(obs_addr), 256'(32'hAA0));
      serve(2, a5);
      chk("mid_d_resp", 256'(obs_dresp), 256'(1));
      ifc.d_read = 0;
      cycle();

      // Random traffic from both caches and a random-latency memory
      for (int n = 0; n < 3000; n++) begin
         if (obs_iresp) ifc.i_read = 0;
         else if (!ifc.i_read) begin
            if ($urandom_range(0, 3) == 0) begin
               ifc.i_read = 1; ifc.i_address = $urandom;
            end
         end else if ($urandom_range(0, 3) == 0) ifc.i_address = $urandom;

         if (obs_dresp) begin
            ifc.d_read = 0; ifc.d_write = 0;
         end else if (!(ifc.d_read || ifc.d_write)) begin
            if ($urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 1) ifc.d_write = 1; else ifc.d_read = 1;
               ifc.d_address = $urandom;
               ifc.d_wdata = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
            end
         end else if ($urandom_range(0, 2) == 0) begin
            ifc.d_address = $urandom;
            ifc.d_wdata = {8{$urandom}};
         end

         ifc.mem_rdata = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
         if (m_owner != 0) ifc.mem_resp = ($urandom_range(0, 2) == 0);
         else              ifc.mem_resp = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
